// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature decoder: channel state
// encodings, the decoded transition event and the error counter width.
package quad_pkg;

   typedef enum logic [1:0] {
      QS_00 = 2'b00,
      QS_01 = 2'b01,
      QS_10 = 2'b10,
      QS_11 = 2'b11
   } quad_state_t;

   typedef enum logic [1:0] {
      EVT_NONE    = 2'd0,
      EVT_FWD     = 2'd1,
      EVT_REV     = 2'd2,
      EVT_ILLEGAL = 2'd3
   } quad_evt_t;

   localparam int ERR_CNT_W = 8;

   // Successor of a state in the forward (A leads B) cycle 00->10->11->01->00.
   function automatic quad_state_t nextFwd(input quad_state_t s);
      case (s)
         QS_00:   nextFwd = QS_10;
         QS_10:   nextFwd = QS_11;
         QS_11:   nextFwd = QS_01;
         default: nextFwd = QS_00;
      endcase
   endfunction

   // Classify one prev->cur transition of the {A,B} pair.
   function automatic quad_evt_t quadDecode(input quad_state_t prevS, input quad_state_t curS);
      if (prevS == curS)
         quadDecode = EVT_NONE;
      else if (curS == nextFwd(prevS))
         quadDecode = EVT_FWD;
      else if (prevS == nextFwd(curS))
         quadDecode = EVT_REV;
      else
         quadDecode = EVT_ILLEGAL;
   endfunction

endpackage

// File: rtl/quad_vel_meter.sv
// Windowed velocity measurement: counts signed steps over a fixed window of
// clock cycles and publishes the net count at the end of every window.
module quad_vel_meter #(
   parameter int VEL_W      = 16,
   parameter int VEL_WINDOW = 100000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    step_i,
   input  logic                    dir_i,
   output logic signed [VEL_W-1:0] velocity_o,
   output logic                    vel_valid_o
);

   localparam int CW = (VEL_WINDOW > 2) ? $clog2(VEL_WINDOW) : 1;
   localparam logic [CW-1:0]          WIN_LAST = CW'(VEL_WINDOW - 1);
   localparam logic signed [VEL_W-1:0] VEL_MAX  = {1'b0, {(VEL_W-1){1'b1}}};
   localparam logic signed [VEL_W-1:0] VEL_MIN  = {1'b1, {(VEL_W-1){1'b0}}};

   logic [CW-1:0]          win_q;
   logic signed [VEL_W-1:0] acc_q;
   logic signed [VEL_W-1:0] acc_d;
   logic signed [VEL_W-1:0] velocity_q;
   logic                    velValid_q;

   // Saturating accumulation of this cycle's step, visible to the window end.
   always_comb begin
      acc_d = acc_q;
      if (step_i) begin
         if (dir_i && (acc_q != VEL_MAX))
            acc_d = acc_q + VEL_W'(1);
         else if (!dir_i && (acc_q != VEL_MIN))
            acc_d = acc_q - VEL_W'(1);
      end
   end

   // Window counter; on the terminal count publish and restart the accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q      <= '0;
         acc_q      <= '0;
         velocity_q <= '0;
         velValid_q <= 1'b0;
      end else begin
         velValid_q <= 1'b0;
         if (win_q == WIN_LAST) begin
            win_q      <= '0;
            acc_q      <= '0;
            velocity_q <= acc_d;
            velValid_q <= 1'b1;
         end else begin
            win_q <= win_q + CW'(1);
            acc_q <= acc_d;
         end
      end
   end

   assign velocity_o  = velocity_q;
   assign vel_valid_o = velValid_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: turns debounced A/B channels into a wrapping signed
// position, step/dir strobes, a sticky illegal-transition flag with a
// saturating count, and a windowed velocity measurement.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int COUNT_W    = 32,
   parameter int VEL_W      = 16,
   parameter int VEL_WINDOW = 100000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      a_in,
   input  logic                      b_in,
   input  logic                      clr_pos,
   input  logic                      err_clr,
   output logic signed [COUNT_W-1:0] position,
   output logic                      step,
   output logic                      dir,
   output logic                      err,
   output logic [ERR_CNT_W-1:0]      err_cnt,
   output logic signed [VEL_W-1:0]   velocity,
   output logic                      vel_valid
);

   logic [1:0]               cur_q;
   logic [1:0]               prev_q;
   logic                     curValid_q;
   logic                     primed_q;
   quad_evt_t                evt;
   logic [COUNT_W-1:0]       position_q, position_d;
   logic                     step_q, step_d;
   logic                     dir_q, dir_d;
   logic                     err_q, err_d;
   logic [ERR_CNT_W-1:0]     errCnt_q, errCnt_d;

   // Input capture pipeline; compares start only once prev holds a real sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_q      <= 2'b00;
         prev_q     <= 2'b00;
         curValid_q <= 1'b0;
         primed_q   <= 1'b0;
      end else begin
         cur_q      <= {a_in, b_in};
         prev_q     <= cur_q;
         curValid_q <= 1'b1;
         primed_q   <= curValid_q;
      end
   end

   // Decode the transition and work out the next position/strobe/error state.
   always_comb begin
      evt        = EVT_NONE;
      position_d = position_q;
      step_d     = 1'b0;
      dir_d      = dir_q;
      err_d      = err_q;
      errCnt_d   = errCnt_q;
      if (primed_q)
         evt = quadDecode(quad_state_t'(prev_q), quad_state_t'(cur_q));
      case (evt)
         EVT_FWD: begin
            position_d = position_q + COUNT_W'(1);
            step_d     = 1'b1;
            dir_d      = 1'b1;
         end
         EVT_REV: begin
            position_d = position_q - COUNT_W'(1);
            step_d     = 1'b1;
            dir_d      = 1'b0;
         end
         default: ;
      endcase
      if (evt == EVT_ILLEGAL) begin
         err_d = 1'b1;
         if (err_clr)
            errCnt_d = ERR_CNT_W'(1);
         else if (errCnt_q != '1)
            errCnt_d = errCnt_q + ERR_CNT_W'(1);
      end else if (err_clr) begin
         err_d    = 1'b0;
         errCnt_d = '0;
      end
      if (clr_pos)
         position_d = '0;
   end

   // Registered decoder outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         position_q <= '0;
         step_q     <= 1'b0;
         dir_q      <= 1'b0;
         err_q      <= 1'b0;
         errCnt_q   <= '0;
      end else begin
         position_q <= position_d;
         step_q     <= step_d;
         dir_q      <= dir_d;
         err_q      <= err_d;
         errCnt_q   <= errCnt_d;
      end
   end

   quad_vel_meter #(
      .VEL_W      (VEL_W),
      .VEL_WINDOW (VEL_WINDOW)
   ) uVelMeter (
      .clk         (clk),
      .rst_n       (rst_n),
      .step_i      (step_q),
      .dir_i       (dir_q),
      .velocity_o  (velocity),
      .vel_valid_o (vel_valid)
   );

   assign position = position_q;
   assign step     = step_q;
   assign dir      = dir_q;
   assign err      = err_q;
   assign err_cnt  = errCnt_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: a phase-arithmetic reference model
// queues expected step and velocity events, a monitor pops and compares them.
module tb_quad_decoder;

   localparam int COUNT_W    = 8;
   localparam int VEL_W      = 16;
   localparam int VEL_WINDOW = 100;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    a_in = 1'b0;
   logic                    b_in = 1'b0;
   logic                    clr_pos = 1'b0;
   logic                    err_clr = 1'b0;
   logic [COUNT_W-1:0]      position;
   logic                    step;
   logic                    dir;
   logic                    err;
   logic [7:0]              err_cnt;
   logic signed [VEL_W-1:0] velocity;
   logic                    vel_valid;

   quad_decoder #(
      .COUNT_W    (COUNT_W),
      .VEL_W      (VEL_W),
      .VEL_WINDOW (VEL_WINDOW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_in      (a_in),
      .b_in      (b_in),
      .clr_pos   (clr_pos),
      .err_clr   (err_clr),
      .position  (position),
      .step      (step),
      .dir       (dir),
      .err       (err),
      .err_cnt   (err_cnt),
      .velocity  (velocity),
      .vel_valid (vel_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                 edgeN;
      bit                 d;
      logic [COUNT_W-1:0] p;
   } stepExp_t;

   typedef struct {
      int                      edgeN;
      logic signed [VEL_W-1:0] v;
   } velExp_t;

   stepExp_t stepQ[$];
   velExp_t  velQ[$];

   int vectors     = 0;
   int miscompares = 0;
   int curPh       = 0;

   // Reference model state
   int                 edgeNum;
   logic [COUNT_W-1:0] posM;
   bit                 dirM;
   bit                 errM;
   int                 errCntM;
   bit                 haveLast;
   int                 lastPh;
   int                 pendEvt;
   bit                 stepPrevM;
   bit                 dirPrevM;
   int                 velAccM;

   function automatic int phaseOf(input logic [1:0] ab);
      case (ab)
         2'b00:   phaseOf = 0;
         2'b10:   phaseOf = 1;
         2'b11:   phaseOf = 2;
         default: phaseOf = 3;
      endcase
   endfunction

   function automatic logic [1:0] abOf(input int ph);
      case (ph & 3)
         0:       abOf = 2'b00;
         1:       abOf = 2'b10;
         2:       abOf = 2'b11;
         default: abOf = 2'b01;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, expv, $time);
      end
   endtask

   // Behavioural model: phase difference mod 4 classifies each transition;
   // events take effect one edge after the sample that produced them.
   always @(posedge clk or negedge rst_n) begin
      int ph;
      int d;
      if (!rst_n) begin
         edgeNum   = 0;
         posM      = '0;
         dirM      = 1'b0;
         errM      = 1'b0;
         errCntM   = 0;
         haveLast  = 1'b0;
         lastPh    = 0;
         pendEvt   = 0;
         stepPrevM = 1'b0;
         dirPrevM  = 1'b0;
         velAccM   = 0;
         stepQ.delete();
         velQ.delete();
      end else begin
         edgeNum++;
         if (stepPrevM) begin
            velAccM = velAccM + (dirPrevM ? 1 : -1);
            if (velAccM > 32767)  velAccM = 32767;
            if (velAccM < -32768) velAccM = -32768;
         end
         if (edgeNum % VEL_WINDOW == 0) begin
            velQ.push_back('{edgeNum, VEL_W'(velAccM)});
            velAccM = 0;
         end
         stepPrevM = 1'b0;
         if (pendEvt == 1 || pendEvt == -1) begin
            if (clr_pos)          posM = '0;
            else if (pendEvt == 1) posM = posM + 1'b1;
            else                   posM = posM - 1'b1;
            dirM      = (pendEvt == 1);
            stepPrevM = 1'b1;
            dirPrevM  = dirM;
            stepQ.push_back('{edgeNum, dirM, posM});
         end else if (clr_pos) begin
            posM = '0;
         end
         if (pendEvt == 2) begin
            errM    = 1'b1;
            errCntM = err_clr ? 1 : ((errCntM < 255) ? errCntM + 1 : 255);
         end else if (err_clr) begin
            errM    = 1'b0;
            errCntM = 0;
         end
         ph = phaseOf({a_in, b_in});
         if (!haveLast) begin
            haveLast = 1'b1;
            pendEvt  = 0;
         end else begin
            d = (ph - lastPh) & 3;
            pendEvt = (d == 0) ? 0 : (d == 1) ? 1 : (d == 3) ? -1 : 2;
         end
         lastPh = ph;
      end
   end

   // Monitor: sample just after the falling edge, pop expected events when due.
   always @(negedge clk) begin
      bit expStep;
      bit expVel;
      stepExp_t se;
      velExp_t  ve;
      #1;
      if (!rst_n) begin
         checkOutput("reset position", 64'(position), 64'd0);
         checkOutput("reset step", 64'(step), 64'd0);
         checkOutput("reset dir", 64'(dir), 64'd0);
         checkOutput("reset err", 64'(err), 64'd0);
         checkOutput("reset err_cnt", 64'(err_cnt), 64'd0);
         checkOutput("reset velocity", 64'(velocity), 64'd0);
         checkOutput("reset vel_valid", 64'(vel_valid), 64'd0);
      end else begin
         while (stepQ.size() > 0 && stepQ[0].edgeN < edgeNum) void'(stepQ.pop_front());
         while (velQ.size() > 0 && velQ[0].edgeN < edgeNum) void'(velQ.pop_front());
         expStep = (stepQ.size() > 0) && (stepQ[0].edgeN == edgeNum);
         checkOutput("step", 64'(step), 64'(expStep));
         if (expStep) begin
            se = stepQ.pop_front();
            checkOutput("step dir", 64'(dir), 64'(se.d));
            checkOutput("step position", 64'(position), 64'(se.p));
         end
         expVel = (velQ.size() > 0) && (velQ[0].edgeN == edgeNum);
         checkOutput("vel_valid", 64'(vel_valid), 64'(expVel));
         if (expVel) begin
            ve = velQ.pop_front();
            checkOutput("velocity", 64'(velocity), 64'(ve.v));
         end
         checkOutput("position", 64'(position), 64'(posM));
         checkOutput("dir", 64'(dir), 64'(dirM));
         checkOutput("err", 64'(err), 64'(errM));
         checkOutput("err_cnt", 64'(err_cnt), 64'(errCntM));
      end
   end

   // One cycle of stimulus at the current phase.
   task automatic applyStimulus(input bit clr, input bit eclr);
      @(negedge clk);
      {a_in, b_in} = abOf(curPh);
      clr_pos      = clr;
      err_clr      = eclr;
   endtask

   task automatic applyReset(input int ph);
      @(negedge clk);
      rst_n        = 1'b0;
      curPh        = ph;
      {a_in, b_in} = abOf(curPh);
      clr_pos      = 1'b0;
      err_clr      = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic moveAndHold(input int delta, input int edges, input int holdCycles);
      for (int i = 0; i < edges; i++) begin
         curPh = curPh + delta;
         repeat (holdCycles) applyStimulus(1'b0, 1'b0);
      end
   endtask

   initial begin
      int r;
      $display("[TB] starting quad_decoder bench");

      // Idle at 11 straight out of reset
      applyReset(2);
      repeat (10) applyStimulus(1'b0, 1'b0);

      // Forward 5 cycles slowly, then reverse 3 cycles
      applyReset(0);
      moveAndHold(1, 20, 4);
      moveAndHold(-1, 12, 4);

      // Wrap below zero, then across the signed boundary
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      moveAndHold(-1, 1, 3);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      moveAndHold(1, 127, 1);
      moveAndHold(1, 1, 3);

      // Illegal jumps, clearing, saturation, and clear colliding with a set
      moveAndHold(2, 1, 3);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      moveAndHold(2, 300, 1);
      moveAndHold(0, 1, 3);
      curPh = curPh + 2;
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      repeat (2) applyStimulus(1'b0, 1'b0);

      // Velocity window with 30 edges, the last landing on the terminal cycle
      applyReset(0);
      for (int n = 2; n <= 130; n++) begin
         if (((n % 3) == 0 && n <= 87) || n == 98) curPh = curPh + 1;
         applyStimulus(1'b0, 1'b0);
      end

      // Position clear coinciding with a forward step at position 7
      applyStimulus(1'b1, 1'b0);
      moveAndHold(1, 7, 2);
      curPh = curPh + 1;
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      repeat (120) applyStimulus(1'b0, 1'b0);

      // Randomised traffic with occasional clears and mid-window resets
      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 40)       curPh = curPh;
         else if (r < 65)  curPh = curPh + 1;
         else if (r < 85)  curPh = curPh + 3;
         else if (r < 92)  curPh = curPh + 2;
         if ($urandom_range(0, 799) == 0)
            applyReset(curPh);
         else
            applyStimulus($urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0);
      end

      repeat (5) applyStimulus(1'b0, 1'b0);
      checkOutput("pending steps", 64'(stepQ.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature decoder that consumes the debounced A/B encoder channels and produces a signed position count, per-edge step/direction strobes, a sticky illegal-transition flag and a windowed velocity measurement. Sits directly downstream of the encoder input debouncer, in the same clock domain, and feeds the motion-control/register interface logic.

## Interface
- `COUNT_W`, 32: position counter width, two's complement.
- `VEL_W`, 16: velocity output width, two's complement.
- `VEL_WINDOW`, 100000: velocity window length in clk cycles (1 ms at 100 MHz); must be ≥ 2.
- `clk`  in  1  system clock (100 MHz); all logic rises on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_in`  in  1  debounced channel A, synchronous to clk.
- `b_in`  in  1  debounced channel B, synchronous to clk.
- `clr_pos`  in  1  synchronous clear of position, one-cycle pulse.
- `err_clr`  in  1  synchronous clear of err and err_cnt.
- `position`  out  COUNT_W  signed accumulated count.
- `step`  out  1  one-cycle pulse per legal edge.
- `dir`  out  1  direction of last legal edge: 1 = forward, 0 = reverse; holds between steps.
- `err`  out  1  sticky: an illegal (double-bit) transition occurred.
- `err_cnt`  out  8  number of illegal transitions, saturates at 255.
- `velocity`  out  VEL_W  signed net count over last complete window.
- `vel_valid`  out  1  one-cycle pulse when velocity updates.

## Operation
- State is `{A,B}`. `cur` samples `{a_in,b_in}` every cycle; `prev` holds the previous `cur`.
- Forward sequence: 00→10→11→01→00 (A leads B). Reverse is the exact inverse.
- Decode of prev→cur:
  - Equal: no action.
  - Forward: position +1, step=1, dir=1.
  - Reverse: position −1, step=1, dir=0.
  - Both bits changed: illegal. Position unchanged, no step, dir unchanged, err←1, err_cnt+1 (saturating).
- Position wraps modulo 2^COUNT_W in both directions; no saturation.
- clr_pos in the same cycle as a decoded step: position←0. The step is discarded from position but step/dir still pulse and the step still counts toward velocity.
- err_clr with a simultaneous illegal transition: the set wins. err=1, err_cnt=1.
- Priming: the first cycle after reset release only loads `prev` (a `primed` flag). The first compare happens on the next cycle, so idle inputs at 11 after reset never flag an error.
- Velocity:
  - A window counter runs 0..VEL_WINDOW−1; a signed accumulator adds ±1 per legal step, saturating at the VEL_W limits.
  - On the terminal count: velocity←accumulator including the same-cycle step, accumulator←0, vel_valid pulses.
  - clr_pos does not affect velocity.

## Timing
- Reset values (all async on rst_n low): position=0, step=0, dir=0, err=0, err_cnt=0, velocity=0, vel_valid=0. Internally: cur=prev=00, primed=0, window counter=0, accumulator=0.
- Latency: an input change captured into `cur` at edge k drives step/dir/position/err registered at edge k+1 (one cycle after capture). All outputs are registered.
- Sustained rate: one legal edge per cycle is decoded without loss. Each edge produces exactly one step pulse.
- First vel_valid occurs VEL_WINDOW cycles after reset release, then every VEL_WINDOW cycles.
- Reset asserted mid-window discards the partial accumulation. The window restarts at 0 on release.

## Structure
- Package `quad_pkg`:
  - state encodings `QS_00`, `QS_10`, `QS_11`, `QS_01`;
  - a decode function returning {none, fwd, rev, illegal} as enum `quad_evt_t`;
  - `ERR_CNT_W`=8.
- One sub-module: `quad_vel_meter`. It holds the window counter, the saturating accumulator and the velocity/vel_valid registers, and takes the step/dir strobes as input.

## Test plan
- Reset release with a_in=b_in=1 held for 10 cycles → err=0, step never pulses, position=0.
- Forward sequence 00→10→11→01→00 repeated 5 times, one state per 4 cycles → 20 step pulses, dir=1, position=20. Then the reverse sequence 3 times → position=8, dir=0.
- Position at 0 with one reverse edge → position=2^COUNT_W−1 (−1). With COUNT_W=8, start at 127 and apply one forward edge → 0x80.
- Jump 00→11 → err=1, err_cnt=1, position unchanged. Apply err_clr → both 0. Apply 300 illegal jumps → err_cnt=255.
- VEL_WINDOW=100 with 30 forward edges inside window 1 → vel_valid at cycle 100 after release, velocity=30. An edge on the terminal cycle is included in that window.
- clr_pos coincident with a forward edge at position=7 → position=0, step=1, dir=1, and that window's velocity still counts the edge.
